// File: rtl/seg7_capture_encoder.sv
`default_nettype none
// ============================================================================
// Module  : seg7_capture_encoder
// Brief   : Snoops a multiplexed active-low 7-segment bus and reports each
//           newly stable digit pattern as a glyph code on a valid/ready port.
// Rev     : 1.0
// ============================================================================
module seg7_capture_encoder #(
    parameter int DIGITS = 4,
    parameter int IDXW   = 2,
    parameter int STABLE = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [6:0]        i_seg,
    input  logic [DIGITS-1:0] i_an,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [IDXW-1:0]   o_index,
    output logic [3:0]        o_code,
    output logic              o_blank,
    output logic              o_unknown
);

    localparam logic [3:0] C_STABLE = 4'(STABLE);
    localparam logic [6:0] C_BLANK  = 7'b1111111;

    logic [6:0]        r_cur [DIGITS];
    logic [3:0]        r_cnt [DIGITS];
    logic [6:0]        r_rep [DIGITS];
    logic [6:0]        r_pat [DIGITS];
    logic [DIGITS-1:0] r_rep_v;
    logic [DIGITS-1:0] r_pend;

    logic              r_valid;
    logic [IDXW-1:0]   r_index;
    logic [3:0]        r_code;
    logic              r_blank;
    logic              r_unknown;

    logic [DIGITS-1:0] w_an_act;
    logic              w_samp;
    logic [IDXW-1:0]   w_samp_idx;
    logic [3:0]        w_cnt_base;
    logic [3:0]        w_cnt_nxt;
    logic              w_qual;

    logic              w_free;
    logic              w_pend_any;
    logic [IDXW-1:0]   w_pend_idx;
    logic [6:0]        w_pat_sel;
    logic [3:0]        w_enc_code;
    logic              w_enc_blank;
    logic              w_enc_unknown;

    // Sample qualification for the digit addressed by the single low anode
    always_comb begin
        w_an_act   = ~i_an;
        w_samp     = $onehot(w_an_act);
        w_samp_idx = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_an_act[k]) begin
                w_samp_idx = IDXW'(k);
            end
        end

        // A pattern change restarts the run from zero, so with STABLE=1 the
        // first sample of every new pattern still counts as a fresh crossing.
        w_cnt_base = (i_seg == r_cur[w_samp_idx]) ? r_cnt[w_samp_idx] : 4'd0;
        w_cnt_nxt  = (w_cnt_base >= C_STABLE) ? C_STABLE : w_cnt_base + 4'd1;
        w_qual     = w_samp && (w_cnt_nxt == C_STABLE) && (w_cnt_base < C_STABLE) &&
                     (!r_rep_v[w_samp_idx] || (i_seg != r_rep[w_samp_idx]));
    end

    // Lowest pending digit wins the output register
    always_comb begin
        w_free     = !r_valid || i_ready;
        w_pend_any = |r_pend;
        w_pend_idx = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (r_pend[k]) begin
                w_pend_idx = IDXW'(k);
            end
        end
        w_pat_sel     = r_pat[w_pend_idx];
        w_enc_code    = 4'd0;
        w_enc_blank   = 1'b0;
        w_enc_unknown = 1'b0;
        case (w_pat_sel)
            7'b1000000: w_enc_code = 4'd0;
            7'b1111001: w_enc_code = 4'd1;
            7'b0100100: w_enc_code = 4'd2;
            7'b0110000: w_enc_code = 4'd3;
            7'b0011001: w_enc_code = 4'd4;
            7'b0010010: w_enc_code = 4'd5;
            7'b0000010: w_enc_code = 4'd6;
            7'b1111000: w_enc_code = 4'd7;
            7'b0000000: w_enc_code = 4'd8;
            7'b0010000: w_enc_code = 4'd9;
            7'b0010001: w_enc_code = 4'd10;
            7'b0100001: w_enc_code = 4'd11;
            7'b0001000: w_enc_code = 4'd12;
            7'b0000110: w_enc_code = 4'd13;
            7'b1001110: w_enc_code = 4'd14;
            7'b1110111: w_enc_code = 4'd15;
            C_BLANK:    w_enc_blank = 1'b1;
            default:    w_enc_unknown = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid   <= 1'b0;
            r_index   <= '0;
            r_code    <= 4'd0;
            r_blank   <= 1'b0;
            r_unknown <= 1'b0;
            r_pend    <= '0;
            r_rep_v   <= '0;
            for (int k = 0; k < DIGITS; k++) begin
                r_cur[k] <= C_BLANK;
                r_cnt[k] <= 4'd0;
                r_rep[k] <= 7'd0;
                r_pat[k] <= 7'd0;
            end
        end else begin
            if (w_free) begin
                r_valid <= w_pend_any;
                if (w_pend_any) begin
                    r_index             <= w_pend_idx;
                    r_code              <= w_enc_code;
                    r_blank             <= w_enc_blank;
                    r_unknown           <= w_enc_unknown;
                    r_pend[w_pend_idx]  <= 1'b0;
                    r_rep[w_pend_idx]   <= w_pat_sel;
                    r_rep_v[w_pend_idx] <= 1'b1;
                end
            end
            // Placed after the load so a same-cycle re-qualification keeps pend set
            if (w_samp) begin
                r_cur[w_samp_idx] <= i_seg;
                r_cnt[w_samp_idx] <= w_cnt_nxt;
                if (w_qual) begin
                    r_pend[w_samp_idx] <= 1'b1;
                    r_pat[w_samp_idx]  <= i_seg;
                end
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_index   = r_index;
    assign o_code    = r_code;
    assign o_blank   = r_blank;
    assign o_unknown = r_unknown;

endmodule
`default_nettype wire
